// File: rtl/clk_period_meter_if.sv
// Bus between clk_period_meter and its consumer.
// The meter drives the measurement results and samples the measured clock clk_in.
// high_time exists only when CLK_MEAS_DUTY_EN is defined.
interface clk_period_meter_if #(
  parameter int CNT_W = 16
);
  logic             clk_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             timeout;
  logic             stopped;
`ifdef CLK_MEAS_DUTY_EN
  logic [CNT_W-1:0] high_time;

  modport master (
    input  clk_in,
    output period, period_valid, timeout, stopped, high_time
  );

  modport slave (
    output clk_in,
    input  period, period_valid, timeout, stopped, high_time
  );
`else
  modport master (
    input  clk_in,
    output period, period_valid, timeout, stopped
  );

  modport slave (
    output clk_in,
    input  period, period_valid, timeout, stopped
  );
`endif
endinterface

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period of a slow asynchronous clock (clk_in) in
// cycles of clk. clk_in is synchronised, rising edges are detected and the clk
// cycles between consecutive rising edges are counted. A result is published with
// a one-cycle period_valid strobe; a missing edge for TIMEOUT cycles raises a
// one-cycle timeout pulse and the stopped level.
// Optional feature macro: CLK_MEAS_DUTY_EN adds a high-time counter and the
// high_time output (clk cycles clk_in was high during the last period).
module clk_period_meter #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 65535,
  parameter int SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  clk_period_meter_if.master bus
);

  // Elaboration-time parameter sanity: the counter must never wrap before TIMEOUT.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("clk_period_meter: SYNC_STAGES must be at least 2");
  end
  if ((TIMEOUT < 2) || (longint'(TIMEOUT) > ((longint'(1) << CNT_W) - 1))) begin : g_bad_timeout
    $error("clk_period_meter: TIMEOUT must be in 2..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;
  logic                   s_d_reg;
  logic                   rise;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic             period_valid_reg, period_valid_next;
  logic             timeout_reg, timeout_next;
  logic             stopped_reg, stopped_next;

  // Shift clk_in through the synchroniser chain; the last stage is safe to use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.clk_in};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  // Delayed copy of the synchronised level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_d_reg <= 1'b0;
    end else begin
      s_d_reg <= s;
    end
  end

  assign rise = s & ~s_d_reg;

`ifdef CLK_MEAS_DUTY_EN
  logic [CNT_W-1:0] hi_cnt_reg, hi_cnt_next;
  logic [CNT_W-1:0] high_time_reg, high_time_next;
  logic [CNT_W-1:0] s_inc;

  // The high-time counter restarts on every rise, counting that cycle if s is high.
  assign s_inc = s ? ONE : '0;
`endif

  // Next-state logic: IDLE waits for the arming edge, MEAS counts and publishes.
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    period_next       = period_reg;
    period_valid_next = 1'b0;
    timeout_next      = 1'b0;
    stopped_next      = stopped_reg;
`ifdef CLK_MEAS_DUTY_EN
    hi_cnt_next       = hi_cnt_reg;
    high_time_next    = high_time_reg;
`endif
    case (state_reg)
      IDLE: begin
        // The first edge only arms the measurement; nothing is published.
        if (rise) begin
          state_next = MEAS;
          cnt_next   = ONE;
`ifdef CLK_MEAS_DUTY_EN
          hi_cnt_next = s_inc;
`endif
        end
      end
      MEAS: begin
        if (rise) begin
          // A rise on the same cycle as cnt == TIMEOUT still counts as a valid period.
          period_next       = cnt_reg;
          period_valid_next = 1'b1;
          cnt_next          = ONE;
          stopped_next      = 1'b0;
`ifdef CLK_MEAS_DUTY_EN
          high_time_next = hi_cnt_reg;
          hi_cnt_next    = s_inc;
`endif
        end else if (cnt_reg == TIMEOUT_C) begin
          // Loss of clock: drop back to IDLE so a new edge must re-arm.
          timeout_next = 1'b1;
          stopped_next = 1'b1;
          state_next   = IDLE;
          cnt_next     = '0;
`ifdef CLK_MEAS_DUTY_EN
          hi_cnt_next = '0;
`endif
        end else begin
          cnt_next = cnt_reg + ONE;
`ifdef CLK_MEAS_DUTY_EN
          hi_cnt_next = hi_cnt_reg + s_inc;
`endif
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counters and registered outputs; reset discards any partial count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      period_reg       <= '0;
      period_valid_reg <= 1'b0;
      timeout_reg      <= 1'b0;
      stopped_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      period_reg       <= period_next;
      period_valid_reg <= period_valid_next;
      timeout_reg      <= timeout_next;
      stopped_reg      <= stopped_next;
    end
  end

`ifdef CLK_MEAS_DUTY_EN
  // High-time counter and its published value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_cnt_reg    <= '0;
      high_time_reg <= '0;
    end else begin
      hi_cnt_reg    <= hi_cnt_next;
      high_time_reg <= high_time_next;
    end
  end

  assign bus.high_time = high_time_reg;
`endif

  assign bus.period       = period_reg;
  assign bus.period_valid = period_valid_reg;
  assign bus.timeout      = timeout_reg;
  assign bus.stopped      = stopped_reg;

endmodule
